// File: rtl/payload_pkg.sv
// payload_pkg: shared layout of the 80-byte order-report payload frame.
// Latency: n/a (constants, types and a pure decode function only).
// Backpressure: n/a.
//
// Shared by the payload builder (transmit) and payload_rx (receive). Byte
// offsets are chained from field widths so the map cannot drift out of order.
package payload_pkg;

    localparam int BEAT_BYTES  = 32;
    localparam int BEAT_BITS   = BEAT_BYTES * 8;
    localparam int FRAME_BEATS = 3;
    localparam int FRAME_BITS  = FRAME_BEATS * BEAT_BITS;

    localparam logic [15:0] EXP_LEN_DEFAULT      = 16'd77;
    localparam logic [7:0]  EXP_MSG_TYPE_DEFAULT = 8'd101;

    // Byte offsets within the frame (byte k of beat b is frame byte 32*b+k).
    localparam int OFF_MSG_LENGTH      = 0;                       // 2, big-endian
    localparam int OFF_MSG_SEQ_NUM     = OFF_MSG_LENGTH + 2;      // 4
    localparam int OFF_EPOCH_S         = OFF_MSG_SEQ_NUM + 4;     // 4
    localparam int OFF_MS              = OFF_EPOCH_S + 4;         // 2
    localparam int OFF_MSG_TYPE        = OFF_MS + 2;              // 1
    localparam int OFF_HDR_FCM_ID      = OFF_MSG_TYPE + 1;        // 2
    localparam int OFF_SESSION_ID      = OFF_HDR_FCM_ID + 2;      // 2
    localparam int OFF_EXEC_TYPE       = OFF_SESSION_ID + 2;      // 1
    localparam int OFF_CM_ID           = OFF_EXEC_TYPE + 1;       // 2
    localparam int OFF_FCM_ID          = OFF_CM_ID + 2;           // 2
    localparam int OFF_ORDER_NO        = OFF_FCM_ID + 2;          // 5, order_no4 first
    localparam int OFF_ORD_ID          = OFF_ORDER_NO + 5;        // 4
    localparam int OFF_USER_DEFINE     = OFF_ORD_ID + 4;          // 8, user_define7 first
    localparam int OFF_SYMBOL_TYPE     = OFF_USER_DEFINE + 8;     // 1
    localparam int OFF_SYM             = OFF_SYMBOL_TYPE + 1;     // 20
    localparam int OFF_PRICE           = OFF_SYM + 20;            // 4
    localparam int OFF_QTY             = OFF_PRICE + 4;           // 2
    localparam int OFF_INVESTOR_ACNO   = OFF_QTY + 2;             // 4
    localparam int OFF_INVESTOR_FLAG   = OFF_INVESTOR_ACNO + 4;   // 1
    localparam int OFF_SIDE            = OFF_INVESTOR_FLAG + 1;
    localparam int OFF_ORD_TYPE        = OFF_SIDE + 1;
    localparam int OFF_TIME_IN_FORCE   = OFF_ORD_TYPE + 1;
    localparam int OFF_POSITION_EFFECT = OFF_TIME_IN_FORCE + 1;
    localparam int OFF_ORDER_SOURCE    = OFF_POSITION_EFFECT + 1;
    localparam int OFF_INFO_SOURCE     = OFF_ORDER_SOURCE + 1;    // 3, not decoded
    localparam int CHK_IDX             = OFF_INFO_SOURCE + 3;     // 79

    // Bytes of the last beat that are covered by the checksum (frame bytes 64..78).
    localparam int B2_SUM_BYTES = CHK_IDX - (FRAME_BEATS - 1) * BEAT_BYTES;

    // Receive FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_B0   = 2'd0;
    localparam state_t ST_B1   = 2'd1;
    localparam state_t ST_B2   = 2'd2;
    localparam state_t ST_DROP = 2'd3;

    typedef struct packed {
        logic [31:0]      msg_seq_num, epoch_s, ord_id, price, investor_acno;
        logic [15:0]      ms, session_id, cm_id, qty;
        logic [7:0]       exec_type, symbol_type, investor_flag, side;
        logic [7:0]       ord_type, time_in_force, position_effect, order_source;
        logic [4:0][7:0]  order_no;      // index k = order_no<k>
        logic [7:0][7:0]  user_define;   // index k = user_define<k>
        logic [159:0]     sym;
    } fields_t;

    // Unpack all published fields from a flat frame (byte 0 = bits [7:0]).
    function automatic fields_t decode_fields(input logic [FRAME_BITS-1:0] f);
        fields_t r;
        r.msg_seq_num     = f[OFF_MSG_SEQ_NUM*8 +: 32];
        r.epoch_s         = f[OFF_EPOCH_S*8 +: 32];
        r.ord_id          = f[OFF_ORD_ID*8 +: 32];
        r.price           = f[OFF_PRICE*8 +: 32];
        r.investor_acno   = f[OFF_INVESTOR_ACNO*8 +: 32];
        r.ms              = f[OFF_MS*8 +: 16];
        r.session_id      = f[OFF_SESSION_ID*8 +: 16];
        r.cm_id           = f[OFF_CM_ID*8 +: 16];
        r.qty             = f[OFF_QTY*8 +: 16];
        r.exec_type       = f[OFF_EXEC_TYPE*8 +: 8];
        r.symbol_type     = f[OFF_SYMBOL_TYPE*8 +: 8];
        r.investor_flag   = f[OFF_INVESTOR_FLAG*8 +: 8];
        r.side            = f[OFF_SIDE*8 +: 8];
        r.ord_type        = f[OFF_ORD_TYPE*8 +: 8];
        r.time_in_force   = f[OFF_TIME_IN_FORCE*8 +: 8];
        r.position_effect = f[OFF_POSITION_EFFECT*8 +: 8];
        r.order_source    = f[OFF_ORDER_SOURCE*8 +: 8];
        // order_no and user_define are sent highest index first.
        for (int k = 0; k < 5; k++)
            r.order_no[k] = f[(OFF_ORDER_NO + 4 - k)*8 +: 8];
        for (int k = 0; k < 8; k++)
            r.user_define[k] = f[(OFF_USER_DEFINE + 7 - k)*8 +: 8];
        r.sym             = f[OFF_SYM*8 +: 160];
        return r;
    endfunction

endpackage

// File: rtl/payload_bytesum.sv
// payload_bytesum: unsigned sum of the low N bytes of a 256-bit word.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: dat (256-bit word, byte k = bits [8k+7:8k]), sum (16-bit total).
module payload_bytesum #(
    parameter int N = 32
) (
    input  logic [255:0] dat,
    output logic [15:0]  sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            sum = sum + {8'd0, dat[8*i +: 8]};
    end

    // Bytes at and above N are deliberately left out of the sum.
    logic unused_dat;
    assign unused_dat = ^dat;

endmodule

// File: rtl/payload_rx.sv
// payload_rx: AXI-Stream receiver/decoder for the 3-beat order-report payload frame.
// Latency: fields/msg_valid/chk_err/hdr_err one cycle after the last-beat handshake; frame_err one cycle after the offending handshake.
// Backpressure: none; s_tready is 1 from the first clock after reset release, every valid beat is consumed.
//
// Ports: clk, resetn (async active-low); s_tdata/s_tvalid/s_tlast/s_tkeep stream sink (s_tkeep ignored),
// s_tready; msg_valid pulse with chk_err/hdr_err flags; frame_err pulse on wrong beat count;
// decoded field outputs held until the next publish.
// Optional: define PAYLOAD_RX_STATS_EN to add good_cnt/err_cnt event counters.
module payload_rx
    import payload_pkg::*;
#(
    parameter logic [15:0] EXP_LEN      = EXP_LEN_DEFAULT,
    parameter logic [7:0]  EXP_MSG_TYPE = EXP_MSG_TYPE_DEFAULT,
    parameter bit          HDR_CHECK    = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [255:0] s_tdata,
    input  logic         s_tvalid,
    input  logic         s_tlast,
    input  logic [31:0]  s_tkeep,
    output logic         s_tready,
    output logic         msg_valid,
    output logic         chk_err,
    output logic         hdr_err,
    output logic         frame_err,
    output logic [31:0]  MsgSeqNum,
    output logic [31:0]  epoch_s,
    output logic [31:0]  ord_id,
    output logic [31:0]  price,
    output logic [31:0]  investor_acno,
    output logic [15:0]  ms,
    output logic [15:0]  session_id,
    output logic [15:0]  cm_id,
    output logic [15:0]  qty,
    output logic [7:0]   ExecType,
    output logic [7:0]   symbol_type,
    output logic [7:0]   investor_flag,
    output logic [7:0]   side,
    output logic [7:0]   OrdType,
    output logic [7:0]   TimeInForce,
    output logic [7:0]   PositionEffect,
    output logic [7:0]   order_source,
    output logic [7:0]   order_no0,
    output logic [7:0]   order_no1,
    output logic [7:0]   order_no2,
    output logic [7:0]   order_no3,
    output logic [7:0]   order_no4,
    output logic [7:0]   user_define0,
    output logic [7:0]   user_define1,
    output logic [7:0]   user_define2,
    output logic [7:0]   user_define3,
    output logic [7:0]   user_define4,
    output logic [7:0]   user_define5,
    output logic [7:0]   user_define6,
    output logic [7:0]   user_define7,
    output logic [159:0] sym
`ifdef PAYLOAD_RX_STATS_EN
    ,
    output logic [31:0]  good_cnt,
    output logic [31:0]  err_cnt
`endif
);

    state_t          state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic [255:0]    beat0_q, beat0_d;
    logic [255:0]    beat1_q, beat1_d;
    fields_t         fields_q, fields_d;
    logic            msg_valid_q, msg_valid_d;
    logic            chk_err_q, chk_err_d;
    logic            hdr_err_q, hdr_err_d;
    logic            frame_err_q, frame_err_d;
    logic            tready_q, tready_d;

    logic            hs;
    logic [15:0]     sum_full;
    logic [15:0]     sum_b2;
    logic [15:0]     total;
    logic [FRAME_BITS-1:0] frame;
    fields_t         dec;
    logic [15:0]     rx_len;
    logic [7:0]      rx_type;
    logic [7:0]      rx_chk;

    payload_bytesum #(.N(BEAT_BYTES)) u_sum_full (
        .dat (s_tdata),
        .sum (sum_full)
    );

    payload_bytesum #(.N(B2_SUM_BYTES)) u_sum_b2 (
        .dat (s_tdata),
        .sum (sum_b2)
    );

    assign hs    = s_tvalid & tready_q;
    // The last beat is decoded straight off the bus, so only beats 0/1 are stored.
    assign frame = {s_tdata, beat1_q, beat0_q};
    assign dec   = decode_fields(frame);
    assign total = acc_q + sum_b2;

    // msg_length is the one big-endian field: frame byte 0 is its high byte.
    assign rx_len  = {frame[OFF_MSG_LENGTH*8 +: 8], frame[(OFF_MSG_LENGTH+1)*8 +: 8]};
    assign rx_type = frame[OFF_MSG_TYPE*8 +: 8];
    assign rx_chk  = frame[CHK_IDX*8 +: 8];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat0_d     = beat0_q;
        beat1_d     = beat1_q;
        fields_d    = fields_q;
        chk_err_d   = chk_err_q;
        hdr_err_d   = hdr_err_q;
        msg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        tready_d    = 1'b1;

        if (hs) begin
            case (state_q)
                ST_B0: begin
                    beat0_d = s_tdata;
                    acc_d   = sum_full;
                    if (s_tlast) frame_err_d = 1'b1;
                    else         state_d     = ST_B1;
                end
                ST_B1: begin
                    beat1_d = s_tdata;
                    acc_d   = acc_q + sum_full;
                    if (s_tlast) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_B0;
                    end else begin
                        state_d     = ST_B2;
                    end
                end
                ST_B2: begin
                    acc_d = total;
                    if (s_tlast) begin
                        fields_d    = dec;
                        chk_err_d   = (total[7:0] != rx_chk);
                        hdr_err_d   = HDR_CHECK &&
                                      ((rx_len != EXP_LEN) || (rx_type != EXP_MSG_TYPE));
                        msg_valid_d = 1'b1;
                        state_d     = ST_B0;
                    end else begin
                        // Over-long frame: swallow the rest, report at its tlast.
                        state_d     = ST_DROP;
                    end
                end
                default: begin
                    if (s_tlast) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_B0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_B0;
            acc_q       <= '0;
            beat0_q     <= '0;
            beat1_q     <= '0;
            fields_q    <= '0;
            msg_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat0_q     <= beat0_d;
            beat1_q     <= beat1_d;
            fields_q    <= fields_d;
            msg_valid_q <= msg_valid_d;
            chk_err_q   <= chk_err_d;
            hdr_err_q   <= hdr_err_d;
            frame_err_q <= frame_err_d;
            tready_q    <= tready_d;
        end
    end

`ifdef PAYLOAD_RX_STATS_EN
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // chk_err_d/hdr_err_d only carry this frame's verdict when msg_valid_d is set.
    always_comb begin
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (msg_valid_d && !chk_err_d && !hdr_err_d)
            good_cnt_d = good_cnt_q + 32'd1;
        if (frame_err_d || (msg_valid_d && (chk_err_d || hdr_err_d)))
            err_cnt_d = err_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

    assign s_tready       = tready_q;
    assign msg_valid      = msg_valid_q;
    assign chk_err        = chk_err_q;
    assign hdr_err        = hdr_err_q;
    assign frame_err      = frame_err_q;
    assign MsgSeqNum      = fields_q.msg_seq_num;
    assign epoch_s        = fields_q.epoch_s;
    assign ord_id         = fields_q.ord_id;
    assign price          = fields_q.price;
    assign investor_acno  = fields_q.investor_acno;
    assign ms             = fields_q.ms;
    assign session_id     = fields_q.session_id;
    assign cm_id          = fields_q.cm_id;
    assign qty            = fields_q.qty;
    assign ExecType       = fields_q.exec_type;
    assign symbol_type    = fields_q.symbol_type;
    assign investor_flag  = fields_q.investor_flag;
    assign side           = fields_q.side;
    assign OrdType        = fields_q.ord_type;
    assign TimeInForce    = fields_q.time_in_force;
    assign PositionEffect = fields_q.position_effect;
    assign order_source   = fields_q.order_source;
    assign order_no0      = fields_q.order_no[0];
    assign order_no1      = fields_q.order_no[1];
    assign order_no2      = fields_q.order_no[2];
    assign order_no3      = fields_q.order_no[3];
    assign order_no4      = fields_q.order_no[4];
    assign user_define0   = fields_q.user_define[0];
    assign user_define1   = fields_q.user_define[1];
    assign user_define2   = fields_q.user_define[2];
    assign user_define3   = fields_q.user_define[3];
    assign user_define4   = fields_q.user_define[4];
    assign user_define5   = fields_q.user_define[5];
    assign user_define6   = fields_q.user_define[6];
    assign user_define7   = fields_q.user_define[7];
    assign sym            = fields_q.sym;

    // s_tkeep is not used for decode; the whole frame feeds a function,
    // so fold both here to mark the non-decoded bytes as intentionally idle.
    logic unused_bits;
    assign unused_bits = ^{s_tkeep, frame};

endmodule

// File: tb/tb_payload_rx.sv
// tb_payload_rx: directed self-checking bench for payload_rx.
// Drives frames built byte-by-byte from hand-chosen field values and compares
// the decoded outputs against those constants; a second instance has HDR_CHECK=0.
module tb_payload_rx;

    logic         clk;
    logic         resetn;
    logic [255:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic [31:0]  s_tkeep;

    logic         s_tready, msg_valid, chk_err, hdr_err, frame_err;
    logic [31:0]  MsgSeqNum, epoch_s, ord_id, price, investor_acno;
    logic [15:0]  ms, session_id, cm_id, qty;
    logic [7:0]   ExecType, symbol_type, investor_flag, side, OrdType, TimeInForce;
    logic [7:0]   PositionEffect, order_source;
    logic [7:0]   order_no0, order_no1, order_no2, order_no3, order_no4;
    logic [7:0]   user_define0, user_define1, user_define2, user_define3;
    logic [7:0]   user_define4, user_define5, user_define6, user_define7;
    logic [159:0] sym;

    // Second instance (HDR_CHECK=0) outputs.
    logic         x_tready, x_msg_valid, x_chk_err, x_hdr_err, x_frame_err;
    logic [31:0]  x_seq, x_epoch, x_ord_id, x_price, x_acno;
    logic [15:0]  x_ms, x_session, x_cm_id, x_qty;
    logic [7:0]   x_exec, x_symtype, x_flag, x_side, x_ordtype, x_tif, x_pe, x_src;
    logic [7:0]   x_on0, x_on1, x_on2, x_on3, x_on4;
    logic [7:0]   x_ud0, x_ud1, x_ud2, x_ud3, x_ud4, x_ud5, x_ud6, x_ud7;
    logic [159:0] x_sym;
`ifdef PAYLOAD_RX_STATS_EN
    logic [31:0]  good_cnt, err_cnt, x_good, x_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] fb [128];

    payload_rx u_dut (
        .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tready(s_tready),
        .msg_valid(msg_valid), .chk_err(chk_err), .hdr_err(hdr_err), .frame_err(frame_err),
        .MsgSeqNum(MsgSeqNum), .epoch_s(epoch_s), .ord_id(ord_id), .price(price),
        .investor_acno(investor_acno), .ms(ms), .session_id(session_id), .cm_id(cm_id),
        .qty(qty), .ExecType(ExecType), .symbol_type(symbol_type),
        .investor_flag(investor_flag), .side(side), .OrdType(OrdType),
        .TimeInForce(TimeInForce), .PositionEffect(PositionEffect),
        .order_source(order_source), .order_no0(order_no0), .order_no1(order_no1),
        .order_no2(order_no2), .order_no3(order_no3), .order_no4(order_no4),
        .user_define0(user_define0), .user_define1(user_define1),
        .user_define2(user_define2), .user_define3(user_define3),
        .user_define4(user_define4), .user_define5(user_define5),
        .user_define6(user_define6), .user_define7(user_define7), .sym(sym)
`ifdef PAYLOAD_RX_STATS_EN
        , .good_cnt(good_cnt), .err_cnt(err_cnt)
`endif
    );

    payload_rx #(.HDR_CHECK(1'b0)) u_nohdr (
        .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tready(x_tready),
        .msg_valid(x_msg_valid), .chk_err(x_chk_err), .hdr_err(x_hdr_err),
        .frame_err(x_frame_err), .MsgSeqNum(x_seq), .epoch_s(x_epoch), .ord_id(x_ord_id),
        .price(x_price), .investor_acno(x_acno), .ms(x_ms), .session_id(x_session),
        .cm_id(x_cm_id), .qty(x_qty), .ExecType(x_exec), .symbol_type(x_symtype),
        .investor_flag(x_flag), .side(x_side), .OrdType(x_ordtype), .TimeInForce(x_tif),
        .PositionEffect(x_pe), .order_source(x_src), .order_no0(x_on0), .order_no1(x_on1),
        .order_no2(x_on2), .order_no3(x_on3), .order_no4(x_on4),
        .user_define0(x_ud0), .user_define1(x_ud1), .user_define2(x_ud2),
        .user_define3(x_ud3), .user_define4(x_ud4), .user_define5(x_ud5),
        .user_define6(x_ud6), .user_define7(x_ud7), .sym(x_sym)
`ifdef PAYLOAD_RX_STATS_EN
        , .good_cnt(x_good), .err_cnt(x_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] beat_of(input int b);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[8*i +: 8] = fb[32*b + i];
        return d;
    endfunction

    task automatic drive(input int b, input logic last);
        s_tdata  = beat_of(b);
        s_tvalid = 1'b1;
        s_tlast  = last;
        tick();
    endtask

    task automatic go_idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic send_frame();
        for (int b = 0; b < 3; b++) drive(b, b == 2);
        go_idle();
    endtask

    task automatic fix_csum();
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 79; i++) s = s + fb[i];
        fb[79] = s;
    endtask

    // Golden frame; seq_lo becomes the low byte of MsgSeqNum (0x010203xx).
    task automatic build_golden(input logic [7:0] seq_lo);
        for (int i = 0; i < 128; i++) fb[i] = (i >= 80) ? 8'hEE : 8'h00;
        fb[0]  = 8'h00; fb[1]  = 8'h4D;                                  // msg_length 77
        fb[2]  = seq_lo; fb[3] = 8'h03; fb[4] = 8'h02; fb[5] = 8'h01;
        fb[6]  = 8'hC3; fb[7]  = 8'hB2; fb[8] = 8'hA1; fb[9] = 8'h65;   // epoch_s
        fb[10] = 8'hF4; fb[11] = 8'h01;                                  // ms 500
        fb[12] = 8'h65;                                                  // MessageType 101
        fb[13] = 8'h11; fb[14] = 8'h22;
        fb[15] = 8'h44; fb[16] = 8'h33;                                  // session_id
        fb[17] = 8'h30;
        fb[18] = 8'hEF; fb[19] = 8'hBE;                                  // cm_id
        fb[20] = 8'h55; fb[21] = 8'h66;
        for (int k = 0; k < 5; k++) fb[22 + k] = 8'h41 + 8'(k);          // order_no4..0
        fb[27] = 8'h0D; fb[28] = 8'hF0; fb[29] = 8'hFE; fb[30] = 8'hCA; // ord_id
        for (int k = 0; k < 8; k++) fb[31 + k] = 8'h80 + 8'(k);          // user_define7..0
        fb[39] = 8'h01;
        fb[40] = 8'h54; fb[41] = 8'h58; fb[42] = 8'h46; fb[43] = 8'h43; fb[44] = 8'h34;
        fb[60] = 8'h39; fb[61] = 8'h30;                                  // price 12345
        fb[64] = 8'h07;                                                  // qty 7
        fb[66] = 8'h56; fb[67] = 8'h34; fb[68] = 8'h12;                  // investor_acno
        fb[70] = 8'h4E; fb[71] = 8'h42; fb[72] = 8'h32;
        fb[73] = 8'h30; fb[74] = 8'h4F; fb[75] = 8'h44;
        fb[76] = 8'hA1; fb[77] = 8'hA2; fb[78] = 8'hA3;
        fix_csum();
    endtask

    task automatic check_fields(input logic [7:0] seq_lo);
        chk_eq("MsgSeqNum", MsgSeqNum, {24'h010203, seq_lo});
        chk_eq("epoch_s", epoch_s, 32'h65A1B2C3);
        chk_eq("ms", ms, 16'd500);
        chk_eq("session_id", session_id, 16'h3344);
        chk_eq("ExecType", ExecType, 8'h30);
        chk_eq("cm_id", cm_id, 16'hBEEF);
        chk_eq("order_no4", order_no4, 8'h41);
        chk_eq("order_no3", order_no3, 8'h42);
        chk_eq("order_no2", order_no2, 8'h43);
        chk_eq("order_no1", order_no1, 8'h44);
        chk_eq("order_no0", order_no0, 8'h45);
        chk_eq("ord_id", ord_id, 32'hCAFEF00D);
        chk_eq("user_define7", user_define7, 8'h80);
        chk_eq("user_define6", user_define6, 8'h81);
        chk_eq("user_define5", user_define5, 8'h82);
        chk_eq("user_define4", user_define4, 8'h83);
        chk_eq("user_define3", user_define3, 8'h84);
        chk_eq("user_define2", user_define2, 8'h85);
        chk_eq("user_define1", user_define1, 8'h86);
        chk_eq("user_define0", user_define0, 8'h87);
        chk_eq("symbol_type", symbol_type, 8'h01);
        chk_eq("sym", sym, 160'h3443465854);
        chk_eq("price", price, 32'd12345);
        chk_eq("qty", qty, 16'd7);
        chk_eq("investor_acno", investor_acno, 32'h00123456);
        chk_eq("investor_flag", investor_flag, 8'h4E);
        chk_eq("side", side, 8'h42);
        chk_eq("OrdType", OrdType, 8'h32);
        chk_eq("TimeInForce", TimeInForce, 8'h30);
        chk_eq("PositionEffect", PositionEffect, 8'h4F);
        chk_eq("order_source", order_source, 8'h44);
    endtask

    initial begin
        s_tkeep = '1;
        go_idle();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        tick();
        tick();

        // Reset state.
        chk_eq("rst_tready", s_tready, 1'b0);
        chk_eq("rst_msg_valid", msg_valid, 1'b0);
        chk_eq("rst_frame_err", frame_err, 1'b0);
        chk_eq("rst_chk_err", chk_err, 1'b0);
        chk_eq("rst_hdr_err", hdr_err, 1'b0);
        chk_eq("rst_seq", MsgSeqNum, 32'd0);
        chk_eq("rst_sym", sym, 160'd0);
        #2 resetn = 1'b1;
        chk_eq("tready_before_edge", s_tready, 1'b0);
        tick();
        chk_eq("tready_after_edge", s_tready, 1'b1);

        // Golden frame.
        build_golden(8'h04);
        send_frame();
        chk_eq("gold_msg_valid", msg_valid, 1'b1);
        chk_eq("gold_chk_err", chk_err, 1'b0);
        chk_eq("gold_hdr_err", hdr_err, 1'b0);
        chk_eq("gold_frame_err", frame_err, 1'b0);
        check_fields(8'h04);
        tick();
        chk_eq("gold_pulse_end", msg_valid, 1'b0);
        chk_eq("gold_hold_price", price, 32'd12345);

        // Checksum byte off by one: still publishes, flagged.
        build_golden(8'h05);
        fb[79] = fb[79] + 8'd1;
        send_frame();
        chk_eq("csum_msg_valid", msg_valid, 1'b1);
        chk_eq("csum_chk_err", chk_err, 1'b1);
        chk_eq("csum_hdr_err", hdr_err, 1'b0);
        chk_eq("csum_seq", MsgSeqNum, 32'h01020305);
        chk_eq("csum_qty", qty, 16'd7);
        tick();

        // Bad length/type: only the HDR_CHECK=1 instance flags it.
        build_golden(8'h06);
        fb[1]  = 8'd78;
        fb[12] = 8'd102;
        fix_csum();
        send_frame();
        chk_eq("hdr_msg_valid", msg_valid, 1'b1);
        chk_eq("hdr_hdr_err", hdr_err, 1'b1);
        chk_eq("hdr_chk_err", chk_err, 1'b0);
        chk_eq("nohdr_msg_valid", x_msg_valid, 1'b1);
        chk_eq("nohdr_hdr_err", x_hdr_err, 1'b0);
        tick();

        // Short frame (tlast on beat1), then a good frame.
        build_golden(8'h07);
        drive(0, 1'b0);
        drive(1, 1'b1);
        go_idle();
        chk_eq("short_frame_err", frame_err, 1'b1);
        chk_eq("short_msg_valid", msg_valid, 1'b0);
        tick();
        chk_eq("short_pulse_end", frame_err, 1'b0);
        build_golden(8'h08);
        send_frame();
        chk_eq("recover_msg_valid", msg_valid, 1'b1);
        chk_eq("recover_chk_err", chk_err, 1'b0);
        chk_eq("recover_seq", MsgSeqNum, 32'h01020308);
        tick();

        // Four-beat frame: dropped, one frame_err at the tlast beat.
        build_golden(8'h09);
        drive(0, 1'b0);
        drive(1, 1'b0);
        drive(2, 1'b0);
        chk_eq("long_b2_msg_valid", msg_valid, 1'b0);
        chk_eq("long_b2_frame_err", frame_err, 1'b0);
        drive(3, 1'b1);
        go_idle();
        chk_eq("long_frame_err", frame_err, 1'b1);
        chk_eq("long_msg_valid", msg_valid, 1'b0);
        chk_eq("long_seq_held", MsgSeqNum, 32'h01020308);
        tick();
        chk_eq("long_pulse_end", frame_err, 1'b0);

        // Three back-to-back frames with s_tvalid held high.
        for (int f = 0; f < 3; f++) begin
            build_golden(8'h10 + 8'(f));
            for (int b = 0; b < 3; b++) begin
                drive(b, b == 2);
                chk_eq($sformatf("b2b_f%0d_b%0d_msg_valid", f, b), msg_valid, b == 2);
                if (b == 2)
                    chk_eq($sformatf("b2b_f%0d_seq", f), MsgSeqNum, {24'h010203, 8'h10 + 8'(f)});
            end
        end
        go_idle();
        tick();
        chk_eq("b2b_end_msg_valid", msg_valid, 1'b0);
`ifdef PAYLOAD_RX_STATS_EN
        chk_eq("stats_good_pre", good_cnt, 32'd5);
        chk_eq("stats_err_pre", err_cnt, 32'd4);
`endif

        // Reset mid-frame (after beat1), then a full frame.
        build_golden(8'h20);
        drive(0, 1'b0);
        drive(1, 1'b0);
        go_idle();
        #2 resetn = 1'b0;
        #1;
        chk_eq("midrst_msg_valid", msg_valid, 1'b0);
        chk_eq("midrst_seq", MsgSeqNum, 32'd0);
        chk_eq("midrst_price", price, 32'd0);
        chk_eq("midrst_tready", s_tready, 1'b0);
        tick();
        #2 resetn = 1'b1;
        tick();
        chk_eq("midrst_tready_back", s_tready, 1'b1);
        build_golden(8'h21);
        send_frame();
        chk_eq("post_rst_msg_valid", msg_valid, 1'b1);
        chk_eq("post_rst_chk_err", chk_err, 1'b0);
        chk_eq("post_rst_frame_err", frame_err, 1'b0);
        chk_eq("post_rst_seq", MsgSeqNum, 32'h01020321);
        chk_eq("post_rst_sym", sym, 160'h3443465854);
`ifdef PAYLOAD_RX_STATS_EN
        tick();
        chk_eq("stats_good", good_cnt, 32'd1);
        chk_eq("stats_err", err_cnt, 32'd0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/payload_rx.md
Name: payload_rx

Overview:
- AXI-Stream receiver and decoder for the order-report payload frame that the payload builder emits.
- Accepts the 3-beat, 256-bit frame and verifies the 8-bit byte-sum checksum and the header constants.
- Unpacks every field into registered outputs and presents them with a one-cycle msg_valid pulse.
- Sits on the ingress side (loopback / exchange echo path) in front of order-state tracking logic.

Parameters:
- EXP_LEN, 77, required msg_length value.
- EXP_MSG_TYPE, 101, required MessageType value.
- HDR_CHECK, 1, 1 = compare length/type and flag hdr_err; 0 = hdr_err tied 0.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_tdata  in  256  stream data, byte k of a beat = bits [8k+7:8k]
- s_tvalid  in  1  beat valid
- s_tlast  in  1  last beat of frame
- s_tkeep  in  32  byte enables (ignored for decode; all ones expected)
- s_tready  out  1  always 1 outside reset (no backpressure)
- msg_valid  out  1  one-cycle pulse, decoded fields valid
- chk_err  out  1  qualified by msg_valid: checksum mismatch
- hdr_err  out  1  qualified by msg_valid: msg_length != EXP_LEN or MessageType != EXP_MSG_TYPE
- frame_err  out  1  one-cycle pulse: wrong beat count
- MsgSeqNum/epoch_s/ord_id/price/investor_acno  out  32 each
- ms/session_id/cm_id/qty  out  16 each
- ExecType/symbol_type/investor_flag/side/OrdType/TimeInForce/PositionEffect/order_source  out  8 each
- order_no0..4, user_define0..7  out  8 each
- sym  out  160

Behaviour:
- Frame byte map, 80 bytes over beats 0/1/2 = bytes 0-31/32-63/64-79.
- Multi-byte fields are little-endian (lowest byte = bits [7:0]), except msg_length, which is big-endian (byte0 = [15:8]).
- Byte allocation:
  - 0-1 msg_length; 2-5 MsgSeqNum; 6-9 epoch_s; 10-11 ms; 12 MessageType; 13-14 hdr_fcm_id; 15-16 session_id; 17 ExecType; 18-19 cm_id; 20-21 fcm_id.
  - 22-26 order_no4..order_no0; 27-30 ord_id; 31-38 user_define7..user_define0; 39 symbol_type; 40-59 sym.
  - 60-63 price; 64-65 qty; 66-69 investor_acno; 70 investor_flag; 71 side; 72 OrdType; 73 TimeInForce; 74 PositionEffect; 75 order_source.
  - 76-78 info_source2..0 (discarded); 79 checksum; 80-95 ignored.
- Checksum: (sum of bytes 0..78) mod 256 == byte 79.
  - Partial sums are accumulated per beat in a 16-bit register: beat0 and beat1 add all 32 bytes; beat2 adds bytes 0-14.
  - Compare uses the low 8 bits.
- FSM states: B0, B1, B2, DROP. Handshake = s_tvalid & s_tready.
  - B0: capture beat, acc = beat sum. tlast=1 → frame_err pulse, stay B0; else → B1.
  - B1: capture, acc += sum. tlast=1 → frame_err, → B0; else → B2.
  - B2: capture, acc += sum. tlast=1 → publish, → B0; tlast=0 → DROP.
  - DROP: discard beats until the tlast handshake; then frame_err pulse, → B0.
- Publish:
  - Fields, chk_err and hdr_err are registered; msg_valid=1 exactly one cycle after the B2 handshake.
  - Fields hold until the next publish.
  - A new frame's B0 beat may arrive in the publish cycle (back-to-back frames, no bubble).
- No output is published for any errored frame except chk_err/hdr_err frames, which still publish with the flag set.
- Reset (async, any time, including mid-frame):
  - State B0, acc 0; all field outputs 0.
  - msg_valid, chk_err, hdr_err and frame_err are 0; s_tready is 0 while resetn=0 and 1 from the first clock edge after release.

Optional Feature:
- Macro PAYLOAD_RX_STATS_EN.
- Defined: adds outputs good_cnt[31:0] and err_cnt[31:0].
  - good_cnt increments on publish with no chk_err/hdr_err.
  - err_cnt increments on frame_err or on an errored publish.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package payload_pkg: byte-offset constants for every field, EXP_LEN/EXP_MSG_TYPE defaults, FSM state enum, frame beat count (3), checksum byte index (79).
- The transmitter also uses payload_pkg.
- One sub-module payload_bytesum: combinational sum of N bytes of a 256-bit word, N a parameter, 16-bit result; instantiated for full beats and beat2.

Test Plan:
- Golden frame: MsgSeqNum=0x01020304, price=12345, qty=7, sym="TXFC4", correct checksum → msg_valid one cycle after beat2, all fields match, chk_err=0, hdr_err=0.
- Same frame with byte 79 incremented by 1 → msg_valid=1, chk_err=1, fields still decoded.
- msg_length=78 and MessageType=102 with HDR_CHECK=1 → hdr_err=1; with HDR_CHECK=0 → hdr_err=0.
- tlast on beat1 → frame_err pulse after that handshake, no msg_valid; next good frame decodes correctly.
- 4-beat frame (tlast on beat3) → no msg_valid, one frame_err pulse at beat3; three back-to-back good frames with s_tvalid held high → three msg_valid pulses, spaced 3 cycles.
- resetn dropped after beat1 → outputs 0 immediately; the following full frame decodes correctly; with PAYLOAD_RX_STATS_EN, good_cnt=1 and err_cnt=0.
